// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the multi-cycle RV64M mul/div sequencer.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_MUL    = 4'd0,
    MD_MULH   = 4'd1,
    MD_MULHSU = 4'd2,
    MD_MULHU  = 4'd3,
    MD_MULW   = 4'd4,
    MD_DIV    = 4'd5,
    MD_DIVU   = 4'd6,
    MD_REM    = 4'd7,
    MD_REMU   = 4'd8,
    MD_DIVW   = 4'd9,
    MD_DIVUW  = 4'd10,
    MD_REMW   = 4'd11,
    MD_REMUW  = 4'd12
  } md_op_e;

  // Sequencer states kept as plain constants so legacy code can compare raw codes.
  typedef logic [2:0] md_state_e;
  localparam md_state_e IDLE  = 3'd0;
  localparam md_state_e PREP  = 3'd1;
  localparam md_state_e ITER  = 3'd2;
  localparam md_state_e FIXUP = 3'd3;
  localparam md_state_e DONE  = 3'd4;

  function automatic logic is_div(input md_op_e op);
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU,
      MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: is_div = 1'b1;
      default:                              is_div = 1'b0;
    endcase
  endfunction

  function automatic logic is_rem(input md_op_e op);
    case (op)
      MD_REM, MD_REMU, MD_REMW, MD_REMUW: is_rem = 1'b1;
      default:                            is_rem = 1'b0;
    endcase
  endfunction

  function automatic logic is_word(input md_op_e op);
    case (op)
      MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: is_word = 1'b1;
      default:                                       is_word = 1'b0;
    endcase
  endfunction

  // Both operands treated as two's complement.
  function automatic logic is_signed(input md_op_e op);
    case (op)
      MD_MUL, MD_MULH, MD_MULW, MD_DIV, MD_REM, MD_DIVW, MD_REMW: is_signed = 1'b1;
      default:                                                    is_signed = 1'b0;
    endcase
  endfunction

  // rs1 is signed for the fully-signed ops and for MULHSU.
  function automatic logic rs1_signed(input md_op_e op);
    rs1_signed = is_signed(op) | (op == MD_MULHSU);
  endfunction

  function automatic logic is_mul_hi(input md_op_e op);
    case (op)
      MD_MULH, MD_MULHSU, MD_MULHU: is_mul_hi = 1'b1;
      default:                      is_mul_hi = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: double-width accumulator plus one operand register.
// Multiply: right-shifting shift-add (multiplier in acc low half, multiplicand in opnd).
// Divide: restoring shift-subtract (dividend in acc low half, divisor in opnd);
// quotient ends in the low half, remainder in the high half.
module muldiv_iter_core #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] init_acc,
  input  logic [XLEN-1:0]   init_opnd,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     sub_diff;

  // Partial-product add (with carry-out) and trial subtract of the shifted remainder.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    sub_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  end

  // Load on start, otherwise advance one mul or div step when asked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (start) begin
      acc_q  <= init_acc;
      opnd_q <= init_opnd;
    end else if (step) begin
      if (mode_div) begin
        // sub_diff MSB clear means the shifted remainder covered the divisor.
        if (!sub_diff[XLEN]) acc_q <= {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
        if (acc_q[0]) acc_q <= {add_sum, acc_q[XLEN-1:1]};
        else          acc_q <= {1'b0, acc_q[2*XLEN-1:1]};
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV64M mul/div/rem sequencer for the execute stage.
// Optional build macro MULDIV_FAST_MUL_EN: mul-class ops use one combinational
// 128-bit product loaded during PREP and skip ITER; div/rem always iterate.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_op,
  input  logic [5:0]      req_rd,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [5:0]      resp_rd,
  output logic            stall
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    zext32 = {{(XLEN-32){1'b0}}, v};
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    apply_sign = neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] v, input logic neg);
    apply_sign_wide = neg ? -v : v;
  endfunction

  md_state_e         state, state_nxt;
  logic [5:0]        cnt;
  md_op_e            op_q;
  logic [5:0]        rd_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic              neg_q, spec_q;
  logic [XLEN-1:0]   spec_res_q;

  logic signed [XLEN-1:0] a_ext, b_ext;
  logic              sgn_a, sgn_b, neg_p, div0_p, ovf_p, spec_p, fast_p;
  logic [XLEN-1:0]   mag_a, mag_b, min_p, spec_res_p;
  logic [2*XLEN-1:0] init_acc, core_acc, prod;
  logic [XLEN-1:0]   init_opnd, mul_res, div_res, raw_res, fix_res;
  logic              accept, core_start, core_step;

  assign req_ready  = (state == IDLE) & ~flush;
  assign accept     = req_valid & req_ready;
  assign stall      = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign core_start = (state == PREP);
  assign core_step  = (state == ITER);

  // Operand extension, magnitudes, result sign and divide special cases.
  always_comb begin
    a_ext = a_q;
    b_ext = b_q;
    if (is_word(op_q)) begin
      a_ext = rs1_signed(op_q) ? sext32(a_q[31:0]) : zext32(a_q[31:0]);
      b_ext = is_signed(op_q)  ? sext32(b_q[31:0]) : zext32(b_q[31:0]);
    end
    sgn_a  = rs1_signed(op_q) & a_ext[XLEN-1];
    sgn_b  = is_signed(op_q) & b_ext[XLEN-1];
    mag_a  = apply_sign(a_ext, sgn_a);
    mag_b  = apply_sign(b_ext, sgn_b);
    neg_p  = is_rem(op_q) ? sgn_a : (sgn_a ^ sgn_b);
    min_p  = is_word(op_q) ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div0_p = is_div(op_q) & (b_ext == '0);
    ovf_p  = is_div(op_q) & is_signed(op_q) & (b_ext == '1) & (a_ext == min_p);
    spec_p = div0_p | ovf_p;
    if (div0_p) spec_res_p = is_rem(op_q) ? a_ext : '1;
    else        spec_res_p = is_rem(op_q) ? '0 : a_ext;
  end

  // Core load values; word divides park the 32-bit dividend in the upper low-half bits.
  always_comb begin
    fast_p = 1'b0;
    if (is_div(op_q)) begin
      init_opnd = mag_b;
      init_acc  = is_word(op_q) ? {{XLEN{1'b0}}, mag_a[31:0], 32'b0} : {{XLEN{1'b0}}, mag_a};
    end else begin
      init_opnd = mag_a;
`ifdef MULDIV_FAST_MUL_EN
      fast_p    = 1'b1;
      init_acc  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
      if (is_word(op_q)) init_acc = init_acc << 32;
`else
      init_acc  = {{XLEN{1'b0}}, mag_b};
`endif
    end
  end

  // Sign application and half selection; word products sit at acc[127:32].
  always_comb begin
    prod    = is_word(op_q) ? {32'b0, core_acc[2*XLEN-1:32]} : core_acc;
    prod    = apply_sign_wide(prod, neg_q);
    mul_res = is_mul_hi(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    div_res = is_rem(op_q) ? core_acc[2*XLEN-1:XLEN] : core_acc[XLEN-1:0];
    div_res = apply_sign(div_res, neg_q);
    raw_res = spec_q ? spec_res_q : (is_div(op_q) ? div_res : mul_res);
    fix_res = is_word(op_q) ? sext32(raw_res[31:0]) : raw_res;
  end

  // Next-state decode; flush returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    state_nxt = (spec_p | fast_p) ? FIXUP : ITER;
      ITER:    if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // State register and iteration down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == PREP)      cnt <= is_word(op_q) ? 6'd31 : 6'd63;
      else if (state == ITER) cnt <= cnt - 6'd1;
    end
  end

  // Request capture, PREP decisions and the held response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= MD_MUL;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      resp_result <= '0;
      resp_rd     <= '0;
    end else begin
      if (accept) begin
        op_q <= md_op_e'(req_op);
        rd_q <= req_rd;
        a_q  <= req_rs1;
        b_q  <= req_rs2;
      end
      if (state == PREP) begin
        neg_q      <= neg_p;
        spec_q     <= spec_p;
        spec_res_q <= spec_res_p;
      end
      if (state == FIXUP) begin
        resp_result <= fix_res;
        resp_rd     <= rd_q;
      end
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .step      (core_step),
    .mode_div  (is_div(op_q)),
    .init_acc  (init_acc),
    .init_opnd (init_opnd),
    .acc       (core_acc)
  );

endmodule
